// File: rtl/cpu_bus_unit.sv
// Wishbone classic master shared by instruction fetch and data load/store,
// with lane steering, sign/zero extension, misalignment check, retry and timeout.
//   state   | meaning
//   S_IDLE  | arbitrate requests (data wins), latch request, check alignment
//   S_BUS   | cyc/stb asserted, wait for ack/err/rty or timeout
//   S_RETRY | one idle cycle between retried attempts
//   S_DONE  | done pulse (with err if any) visible to the requester
module cpu_bus_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    fetch_req_i,
  input  logic [ADDR_WIDTH-1:0]   fetch_adr_i,
  output logic [31:0]             fetch_data_o,
  output logic                    fetch_done_o,
  output logic                    fetch_err_o,
  input  logic                    mem_req_i,
  input  logic                    mem_we_i,
  input  logic [1:0]              mem_size_i,
  input  logic                    mem_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]   mem_adr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                    mem_done_o,
  output logic                    mem_err_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic                    ack_i,
  input  logic                    err_i,
  input  logic                    rty_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  output logic                    we_o,
  output logic                    stb_o,
  output logic                    cyc_o
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int LW = $clog2(SW);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RETRY, S_DONE} state_t;
  state_t state_q, state_d;

  logic                  req_fetch_q, req_fetch_d;
  logic [ADDR_WIDTH-1:0] req_adr_q, req_adr_d;
  logic [1:0]            req_size_q, req_size_d;
  logic                  req_we_q, req_we_d;
  logic                  req_uns_q, req_uns_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic [31:0]           retry_q, retry_d;
  logic [31:0]           tmo_q, tmo_d;
  logic                  bus_cyc_q, bus_cyc_d;
  logic                  bus_we_q, bus_we_d;
  logic [SW-1:0]         bus_sel_q, bus_sel_d;
  logic [DATA_WIDTH-1:0] bus_dat_q, bus_dat_d;
  logic [ADDR_WIDTH-1:0] bus_adr_q, bus_adr_d;
  logic                  f_done_q, f_done_d, f_err_q, f_err_d;
  logic [31:0]           f_data_q, f_data_d;
  logic                  m_done_q, m_done_d, m_err_q, m_err_d;
  logic [DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;

  // Request source: live inputs while IDLE so the bus cycle starts next edge,
  // latched copy afterwards so retries replay identical signals.
  logic                  src_fetch, src_we, src_uns;
  logic [ADDR_WIDTH-1:0] src_adr;
  logic [1:0]            src_size;
  logic [DATA_WIDTH-1:0] src_wdata;

  always_comb begin
    if (state_q == S_IDLE) begin
      src_fetch = !mem_req_i;
      src_adr   = mem_req_i ? mem_adr_i : fetch_adr_i;
      src_size  = mem_size_i;
      src_we    = mem_req_i & mem_we_i;
      src_uns   = mem_unsigned_i;
      src_wdata = mem_wdata_i;
    end else begin
      src_fetch = req_fetch_q;
      src_adr   = req_adr_q;
      src_size  = req_size_q;
      src_we    = req_we_q;
      src_uns   = req_uns_q;
      src_wdata = req_wdata_q;
    end
  end

  logic [LW-1:0]         lane;
  logic [7:0]            size_mask;
  logic                  aligned;
  logic [SW-1:0]         sel_calc;
  logic [DATA_WIDTH-1:0] dat_calc;
  logic [ADDR_WIDTH-1:0] adr_calc;

  always_comb begin
    lane = src_adr[LW-1:0];
    case (src_size)
      2'd0:    begin size_mask = 8'h01; aligned = 1'b1; end
      2'd1:    begin size_mask = 8'h03; aligned = !src_adr[0]; end
      2'd2:    begin size_mask = 8'h0F; aligned = (src_adr[1:0] == 2'b00); end
      default: begin size_mask = 8'hFF; aligned = (DATA_WIDTH == 64) && (src_adr[2:0] == 3'b000); end
    endcase
    if (src_fetch) begin
      size_mask = 8'h0F;
      aligned   = (src_adr[1:0] == 2'b00);
    end
    sel_calc = SW'(16'(size_mask) << lane);
    dat_calc = src_we ? (src_wdata << {lane, 3'b000}) : '0;
    adr_calc = {src_adr[ADDR_WIDTH-1:LW], {LW{1'b0}}};
  end

  // Load path: move the addressed lane to bit 0, then extend from the access size.
  logic [DATA_WIDTH-1:0] rd_shift, rd_left, rd_ext;
  logic [6:0]            ext_sh;

  always_comb begin
    rd_shift = dat_i >> {req_adr_q[LW-1:0], 3'b000};
    case (req_size_q)
      2'd0:    ext_sh = 7'(DATA_WIDTH - 8);
      2'd1:    ext_sh = 7'(DATA_WIDTH - 16);
      2'd2:    ext_sh = 7'(DATA_WIDTH - 32);
      default: ext_sh = 7'd0;
    endcase
    rd_left = rd_shift << ext_sh;
    rd_ext  = req_uns_q ? (rd_left >> ext_sh) : DATA_WIDTH'($signed(rd_left) >>> ext_sh);
  end

  logic fin, fin_err;

  always_comb begin
    state_d     = state_q;
    req_fetch_d = req_fetch_q;
    req_adr_d   = req_adr_q;
    req_size_d  = req_size_q;
    req_we_d    = req_we_q;
    req_uns_d   = req_uns_q;
    req_wdata_d = req_wdata_q;
    retry_d     = retry_q;
    tmo_d       = tmo_q;
    fin         = 1'b0;
    fin_err     = 1'b0;
    f_data_d    = '0;
    m_rdata_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (mem_req_i || fetch_req_i) begin
          req_fetch_d = src_fetch;
          req_adr_d   = src_adr;
          req_size_d  = src_size;
          req_we_d    = src_we;
          req_uns_d   = src_uns;
          req_wdata_d = src_wdata;
          retry_d     = '0;
          tmo_d       = '0;
          if (!aligned) begin
            fin     = 1'b1;
            fin_err = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (ack_i) begin
          fin     = 1'b1;
          state_d = S_DONE;
          if (req_fetch_q)   f_data_d  = rd_shift[31:0];
          else if (!req_we_q) m_rdata_d = rd_ext;
        end else if (err_i) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          state_d = S_DONE;
        end else if (rty_i) begin
          if (retry_q < 32'(MAX_RETRY)) begin
            retry_d = retry_q + 32'd1;
            state_d = S_RETRY;
          end else begin
            fin     = 1'b1;
            fin_err = 1'b1;
            state_d = S_DONE;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == 32'(TIMEOUT_CYCLES - 1))) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_RETRY: begin
        tmo_d   = '0;
        state_d = S_BUS;
      end
      S_DONE: begin
        retry_d = '0;
        tmo_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    f_done_d  = fin & src_fetch;
    f_err_d   = fin & fin_err & src_fetch;
    m_done_d  = fin & !src_fetch;
    m_err_d   = fin & fin_err & !src_fetch;
    bus_cyc_d = (state_d == S_BUS);
    bus_we_d  = bus_cyc_d & src_we;
    bus_sel_d = bus_cyc_d ? sel_calc : '0;
    bus_dat_d = bus_cyc_d ? dat_calc : '0;
    bus_adr_d = bus_cyc_d ? adr_calc : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      req_fetch_q <= 1'b0;
      req_adr_q   <= '0;
      req_size_q  <= '0;
      req_we_q    <= 1'b0;
      req_uns_q   <= 1'b0;
      req_wdata_q <= '0;
      retry_q     <= '0;
      tmo_q       <= '0;
      bus_cyc_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_dat_q   <= '0;
      bus_adr_q   <= '0;
      f_done_q    <= 1'b0;
      f_err_q     <= 1'b0;
      f_data_q    <= '0;
      m_done_q    <= 1'b0;
      m_err_q     <= 1'b0;
      m_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_fetch_q <= req_fetch_d;
      req_adr_q   <= req_adr_d;
      req_size_q  <= req_size_d;
      req_we_q    <= req_we_d;
      req_uns_q   <= req_uns_d;
      req_wdata_q <= req_wdata_d;
      retry_q     <= retry_d;
      tmo_q       <= tmo_d;
      bus_cyc_q   <= bus_cyc_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_dat_q   <= bus_dat_d;
      bus_adr_q   <= bus_adr_d;
      f_done_q    <= f_done_d;
      f_err_q     <= f_err_d;
      f_data_q    <= f_data_d;
      m_done_q    <= m_done_d;
      m_err_q     <= m_err_d;
      m_rdata_q   <= m_rdata_d;
    end
  end

  assign cyc_o        = bus_cyc_q;
  assign stb_o        = bus_cyc_q;
  assign we_o         = bus_we_q;
  assign sel_o        = bus_sel_q;
  assign dat_o        = bus_dat_q;
  assign adr_o        = bus_adr_q;
  assign fetch_done_o = f_done_q;
  assign fetch_err_o  = f_err_q;
  assign fetch_data_o = f_data_q;
  assign mem_done_o   = m_done_q;
  assign mem_err_o    = m_err_q;
  assign mem_rdata_o  = m_rdata_q;

endmodule

// File: tb/tb_cpu_bus_unit.sv
// Scoreboard bench for cpu_bus_unit: a 32-bit instance with retry/timeout slave
// behaviour and a 64-bit instance for dword and upper-lane accesses.
module tb_cpu_bus_unit;
  localparam int TO = 4;
  localparam int MR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        f_req = 0, f_done, f_err;
  logic [31:0] f_adr = 0, f_data;
  logic        m_req = 0, m_we = 0, m_uns = 0, m_done, m_err;
  logic [1:0]  m_size = 0;
  logic [31:0] m_adr = 0, m_wdata = 0, m_rdata;
  logic [31:0] dat_i = 0, dat_o, adr_o;
  logic        ack = 0, err = 0, rty = 0, we_o, stb_o, cyc_o;
  logic [3:0]  sel_o;

  cpu_bus_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .fetch_req_i(f_req), .fetch_adr_i(f_adr), .fetch_data_o(f_data),
    .fetch_done_o(f_done), .fetch_err_o(f_err),
    .mem_req_i(m_req), .mem_we_i(m_we), .mem_size_i(m_size), .mem_unsigned_i(m_uns),
    .mem_adr_i(m_adr), .mem_wdata_i(m_wdata), .mem_rdata_o(m_rdata),
    .mem_done_o(m_done), .mem_err_o(m_err),
    .dat_i(dat_i), .ack_i(ack), .err_i(err), .rty_i(rty),
    .dat_o(dat_o), .adr_o(adr_o), .sel_o(sel_o), .we_o(we_o), .stb_o(stb_o), .cyc_o(cyc_o));

  logic        m64_req = 0, m64_we = 0, m64_uns = 0, m64_done, m64_err;
  logic [1:0]  m64_size = 0;
  logic [31:0] m64_adr = 0, f64_data, adr64_o;
  logic [63:0] m64_wdata = 0, m64_rdata, dat64_i = 0, dat64_o;
  logic        f64_done, f64_err, ack64 = 0, we64_o, stb64_o, cyc64_o;
  logic [7:0]  sel64_o;

  cpu_bus_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MAX_RETRY(MR), .TIMEOUT_CYCLES(0)) dut64 (
    .clk_i(clk), .rst_i(rst),
    .fetch_req_i(1'b0), .fetch_adr_i(32'h0), .fetch_data_o(f64_data),
    .fetch_done_o(f64_done), .fetch_err_o(f64_err),
    .mem_req_i(m64_req), .mem_we_i(m64_we), .mem_size_i(m64_size), .mem_unsigned_i(m64_uns),
    .mem_adr_i(m64_adr), .mem_wdata_i(m64_wdata), .mem_rdata_o(m64_rdata),
    .mem_done_o(m64_done), .mem_err_o(m64_err),
    .dat_i(dat64_i), .ack_i(ack64), .err_i(1'b0), .rty_i(1'b0),
    .dat_o(dat64_o), .adr_o(adr64_o), .sel_o(sel64_o), .we_o(we64_o), .stb_o(stb64_o), .cyc_o(cyc64_o));

  typedef struct {
    bit          is_fetch;
    bit          mis;
    bit          we;
    logic [31:0] adr;
    logic [7:0]  sel;
    logic [63:0] dat;
    logic [63:0] rdata;
    logic [31:0] fdata;
    logic [63:0] sd;
    int          rty;
    int          wt;
    bit          eterm;
    bit          noise;
    int          lat;
    int          att;
    bit          err;
    int          k;
  } exp_t;

  exp_t q[$];
  exp_t q64[$];
  int n_chk = 0, n_fail = 0;
  int cyc_cnt = 0, done_cnt = 0, done64_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Reference model: bus width bb bytes, slave plan -> expected lanes, data, outcome, latency.
  function automatic exp_t model(input int bb, input int tmo, input bit isf, input logic [31:0] adr,
                                 input logic [1:0] size, input bit we, input bit uns,
                                 input logic [63:0] wdata, input logic [63:0] sd,
                                 input int rty_n, input int wt, input bit eterm, input bit noise);
    exp_t e;
    int nb, lane;
    logic [63:0] v, mask, full;
    e.is_fetch = isf; e.sd = sd; e.rty = rty_n; e.wt = wt; e.eterm = eterm; e.noise = noise; e.k = 0;
    full = (bb == 4) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    nb   = isf ? 4 : (1 << size);
    lane = int'(adr % bb);
    e.mis = isf ? (adr % 4 != 0) : ((size == 2'd3 && bb == 4) || (adr % nb != 0));
    e.adr = adr - lane;
    e.sel = 8'(((1 << nb) - 1) << lane);
    e.we  = isf ? 1'b0 : we;
    e.dat = e.we ? ((wdata << (8 * lane)) & full) : 64'h0;
    v     = sd >> (8 * lane);
    mask  = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v     = v & mask;
    if (!uns && v[8 * nb - 1]) v = v | ~mask;
    e.rdata = v & full;
    e.fdata = 32'(sd >> (8 * lane));
    if (e.mis) begin
      e.lat = 1; e.att = 0; e.err = 1;
    end else if (rty_n > MR) begin
      e.att = MR + 1; e.lat = 2 + 2 * MR; e.err = 1;
    end else begin
      e.att = rty_n + 1;
      if (tmo != 0 && wt >= tmo) begin e.lat = 1 + 2 * rty_n + tmo; e.err = 1; end
      else begin e.lat = 2 + 2 * rty_n + wt; e.err = eterm; end
    end
    return e;
  endfunction

  // Monitor + slave for the 32-bit instance.
  exp_t me;
  int att = 0, wcnt = 0;
  bit prev_cyc = 0, seen = 0, changed = 0, dirty = 0;
  logic [31:0] b_adr, b_dat;
  logic [3:0]  b_sel;
  logic        b_we;

  always @(negedge clk) begin
    if (rst) begin
      att = 0; wcnt = 0; prev_cyc = 0; seen = 0; changed = 0; dirty = 0;
      ack = 0; err = 0; rty = 0; dat_i = 0;
    end else begin
      if (f_done || m_done) begin
        done_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          me = q.pop_front();
          chk("done_kind_fetch", f_done, me.is_fetch);
          chk("done_kind_mem", m_done, !me.is_fetch);
          chk("done_err", me.is_fetch ? f_err : m_err, me.err);
          if (me.lat >= 0) chk("latency", cyc_cnt - me.k, me.lat);
          chk("bus_attempts", att, me.att);
          if (!me.err && me.is_fetch) chk("fetch_data", f_data, me.fdata);
          if (!me.err && !me.is_fetch && !me.we) chk("load_data", m_rdata, me.rdata);
          if (me.att > 0) begin
            chk("adr_o", b_adr, me.adr);
            chk("sel_o", b_sel, me.sel);
            chk("we_o", b_we, me.we);
            if (me.we) chk("dat_o", b_dat, me.dat);
            chk("bus_stable", changed, 0);
          end
          chk("idle_outputs_zero", dirty, 0);
        end
        att = 0; wcnt = 0; seen = 0; changed = 0; dirty = 0;
      end
      if (!cyc_o && (we_o || sel_o != 0 || dat_o != 0 || stb_o)) dirty = 1;
      if (cyc_o) begin
        if (!stb_o) dirty = 1;
        if (!prev_cyc) begin att++; wcnt = 0; end
        if (!seen) begin
          b_adr = adr_o; b_sel = sel_o; b_we = we_o; b_dat = dat_o; seen = 1;
        end else if (b_adr != adr_o || b_sel != sel_o || b_we != we_o || b_dat != dat_o) begin
          changed = 1;
        end
      end
      prev_cyc = cyc_o;
      ack = 0; err = 0; rty = 0; dat_i = 0;
      if (cyc_o && q.size() > 0) begin
        if (att <= q[0].rty) rty = 1;
        else if (wcnt < q[0].wt) wcnt++;
        else if (q[0].eterm) begin err = 1; rty = q[0].noise; end
        else begin ack = 1; dat_i = q[0].sd[31:0]; err = q[0].noise; rty = q[0].noise; end
      end
    end
  end

  // Monitor + zero-wait slave for the 64-bit instance.
  exp_t me64;
  bit seen64 = 0;
  logic [31:0] b64_adr;
  logic [63:0] b64_dat;
  logic [7:0]  b64_sel;

  always @(negedge clk) begin
    if (rst) begin
      seen64 = 0; ack64 = 0; dat64_i = 0;
    end else begin
      if (m64_done) begin
        done64_cnt++;
        if (q64.size() == 0) begin
          chk("unexpected_done64", 1, 0);
        end else begin
          me64 = q64.pop_front();
          chk("done64_err", m64_err, me64.err);
          chk("latency64", cyc_cnt - me64.k, me64.lat);
          if (!me64.err && !me64.we) chk("load64_data", m64_rdata, me64.rdata);
          if (!me64.mis) begin
            chk("adr64_o", b64_adr, me64.adr);
            chk("sel64_o", b64_sel, me64.sel);
            if (me64.we) chk("dat64_o", b64_dat, me64.dat);
          end
        end
        seen64 = 0;
      end
      if (cyc64_o && !seen64) begin
        b64_adr = adr64_o; b64_sel = sel64_o; b64_dat = dat64_o; seen64 = 1;
      end
      ack64 = 0; dat64_i = 0;
      if (cyc64_o && q64.size() > 0) begin ack64 = 1; dat64_i = q64[0].sd; end
    end
  end

  task automatic wait_cnt(input bit w64, input int target);
    int n = 0;
    while ((w64 ? done64_cnt : done_cnt) < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_within_bound", (w64 ? done64_cnt : done_cnt) >= target, 1);
  endtask

  task automatic do_access(input bit isf, input logic [31:0] adr, input logic [1:0] size, input bit we,
                           input bit uns, input logic [31:0] wd, input logic [31:0] sd,
                           input int rty_n, input int wt, input bit eterm, input bit noise);
    exp_t e;
    int target;
    e = model(4, TO, isf, adr, size, we, uns, {32'h0, wd}, {32'h0, sd}, rty_n, wt, eterm, noise);
    e.k = cyc_cnt;
    target = done_cnt + 1;
    q.push_back(e);
    if (isf) begin
      f_adr = adr; f_req = 1;
    end else begin
      m_adr = adr; m_size = size; m_we = we; m_uns = uns; m_wdata = wd; m_req = 1;
    end
    wait_cnt(0, target);
    f_req = 0; m_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic do64(input logic [31:0] adr, input logic [1:0] size, input bit we, input bit uns,
                      input logic [63:0] wd, input logic [63:0] sd);
    exp_t e;
    int target;
    e = model(8, 0, 0, adr, size, we, uns, wd, sd, 0, 0, 0, 0);
    e.k = cyc_cnt;
    target = done64_cnt + 1;
    q64.push_back(e);
    m64_adr = adr; m64_size = size; m64_we = we; m64_uns = uns; m64_wdata = wd; m64_req = 1;
    wait_cnt(1, target);
    m64_req = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t em, ef;
    int target, n0;
    logic [31:0] a;
    logic [1:0]  sz;
    bit          isf;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", cyc_o, 0);       chk("rst_stb", stb_o, 0);
    chk("rst_we", we_o, 0);         chk("rst_sel", sel_o, 0);
    chk("rst_dat", dat_o, 0);       chk("rst_adr", adr_o, 0);
    chk("rst_fdone", f_done, 0);    chk("rst_ferr", f_err, 0);
    chk("rst_mdone", m_done, 0);    chk("rst_merr", m_err, 0);
    chk("rst_rdata", m_rdata, 0);   chk("rst_fdata", f_data, 0);
    chk("rst_cyc64", cyc64_o, 0);
    rst = 0;
    @(posedge clk); #1;

    // Directed scenarios from the access rules.
    do_access(0, 32'h103, 2'd0, 0, 0, 32'h0, 32'h8000_0000, 0, 0, 0, 0);
    do_access(0, 32'h202, 2'd1, 1, 0, 32'h0000_BEEF, 32'h0, 0, 0, 0, 0);
    do_access(0, 32'h202, 2'd1, 0, 1, 32'h0, 32'h8001_0000, 0, 0, 0, 0);
    do_access(0, 32'h101, 2'd2, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    do_access(1, 32'h002, 2'd0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    do_access(1, 32'h040, 2'd0, 0, 0, 32'h0, 32'h1234_5678, 3, 0, 0, 0);
    do_access(1, 32'h044, 2'd0, 0, 0, 32'h0, 32'h1234_5678, 4, 0, 0, 0);
    do_access(0, 32'h300, 2'd2, 0, 0, 32'h0, 32'h0, 0, 99, 0, 0);
    do_access(0, 32'h304, 2'd2, 0, 0, 32'h0, 32'hCAFE_F00D, 0, 1, 0, 1);
    do_access(0, 32'h308, 2'd2, 0, 0, 32'h0, 32'h0, 0, 0, 1, 1);
    do_access(0, 32'h30C, 2'd3, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);

    // Reset in the middle of a bus cycle: cycle drops, no completion.
    m_adr = 32'h400; m_size = 2'd2; m_we = 0; m_req = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("midbus_cyc_high", cyc_o, 1);
    n0 = done_cnt;
    rst = 1;
    @(posedge clk); #1;
    chk("midbus_rst_cyc", cyc_o, 0);
    chk("midbus_rst_stb", stb_o, 0);
    rst = 0; m_req = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("midbus_no_done", done_cnt, n0);

    // Simultaneous requests: data access first, fetch afterwards.
    em = model(4, TO, 0, 32'h500, 2'd2, 0, 0, 64'h0, 64'h0000_0000_A5A5_5A5A, 0, 0, 0, 0);
    ef = model(4, TO, 1, 32'h600, 2'd0, 0, 0, 64'h0, 64'h0000_0000_1357_9BDF, 0, 0, 0, 0);
    em.k = cyc_cnt; ef.lat = -1;
    target = done_cnt;
    q.push_back(em); q.push_back(ef);
    m_adr = 32'h500; m_size = 2'd2; m_we = 0; m_uns = 0; f_adr = 32'h600;
    m_req = 1; f_req = 1;
    wait_cnt(0, target + 1);
    m_req = 0;
    wait_cnt(0, target + 2);
    f_req = 0;
    @(posedge clk); #1;

    // 64-bit bus: dword, upper lanes.
    do64(32'h008, 2'd3, 0, 0, 64'h0, 64'h8877_6655_4433_2211);
    do64(32'h015, 2'd0, 0, 0, 64'h0, 64'h0000_9A00_0000_0000);
    do64(32'h024, 2'd2, 0, 1, 64'h0, 64'hF000_0001_0000_0000);
    do64(32'h006, 2'd1, 1, 0, 64'h0000_0000_0000_C0DE, 64'h0);
    do64(32'h00C, 2'd3, 0, 0, 64'h0, 64'h0);

    // Randomised traffic on the 32-bit instance.
    for (int i = 0; i < 200; i++) begin
      isf = ($urandom % 4 == 0);
      sz  = 2'($urandom % 4);
      a   = $urandom_range(0, 1023);
      if ($urandom % 4 != 0) a = isf ? (a & ~32'h3) : (a & ~((32'd1 << sz) - 32'd1));
      do_access(isf, a, sz, $urandom % 2, $urandom % 2, $urandom, $urandom,
                ($urandom % 8 < 6) ? 0 : $urandom_range(1, MR + 1),
                ($urandom % 8 == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3),
                ($urandom % 8 == 0), $urandom % 2);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    chk("scoreboard64_empty", q64.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
